// File: rtl/ascon_wb_master.sv
// ascon_wb_master: Wishbone master that loads key/nonce, starts the ASCON core, polls status and reads back the tag.
module ascon_wb_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_LIMIT  = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [4:0]   cmd_ad_len,
  input  logic [6:0]   cmd_datalen,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_nonce,
  output logic [127:0] tag_o,
  output logic         done_o,
  output logic         err_o
);
  typedef enum logic [2:0] {IDLE, WR_KEY, WR_NONCE, WR_CTRL, POLL, RD_TAG, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d, mode_q, mode_d;
  logic [15:0] to_q, to_d, poll_q, poll_d;
  logic busy_q, busy_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, wdat;
  logic [127:0] tag_q, tag_d, key_q, key_d, nonce_q, nonce_d;
  logic [4:0] ad_q, ad_d, widx;
  logic [6:0] len_q, len_d;
  logic bus, ack;
  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = {4{stb_q}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign tag_o     = tag_q;
  assign cmd_ready = state_q == IDLE;
  assign done_o    = state_q == DONE || state_q == ERR;
  assign err_o     = state_q == ERR;
  assign bus       = state_q inside {WR_KEY, WR_NONCE, WR_CTRL, POLL, RD_TAG};
  assign ack       = stb_q & wbm_ack_i;
  always_comb begin
    widx = state_q == WR_KEY   ? 5'd2 + {3'b0, idx_q} :
           state_q == WR_NONCE ? 5'd6 + {3'b0, idx_q} :
           state_q == WR_CTRL  ? 5'd1 :
           state_q == RD_TAG   ? 5'd14 + {3'b0, idx_q} : 5'd0;
    wdat = state_q == WR_KEY   ? key_q[{idx_q, 5'b0} +: 32] :
           state_q == WR_NONCE ? nonce_q[{idx_q, 5'b0} +: 32] :
           state_q == WR_CTRL  ? {16'h0, 1'b1, mode_q, ad_q, 1'b0, len_q} : 32'h0;
    state_d = state_q;
    idx_d   = idx_q;
    to_d    = to_q;
    poll_d  = poll_q;
    busy_d  = busy_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tag_d   = tag_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    mode_d  = mode_q;
    ad_d    = ad_q;
    len_d   = len_q;
    if (state_q == IDLE && cmd_valid) begin
      key_d   = cmd_key;
      nonce_d = cmd_nonce;
      mode_d  = cmd_mode;
      ad_d    = cmd_ad_len;
      len_d   = cmd_datalen;
      idx_d   = 2'd0;
      poll_d  = 16'd0;
      busy_d  = 1'b0;
      state_d = WR_KEY;
    end else if (state_q == DONE || state_q == ERR) begin
      state_d = IDLE;
    end else if (bus && !stb_q) begin
      stb_d = 1'b1;
      to_d  = 16'd0;
      we_d  = state_q inside {WR_KEY, WR_NONCE, WR_CTRL};
      adr_d = BASE_ADDR + {25'b0, widx, 2'b00};
      dat_d = wdat;
    end else if (ack) begin
      stb_d = 1'b0;
      we_d  = 1'b0;
      idx_d = (state_q == WR_CTRL || state_q == POLL) ? 2'd0 : idx_q + 2'd1;
      if (state_q == WR_KEY && idx_q == 2'd3) state_d = WR_NONCE;
      if (state_q == WR_NONCE && idx_q == 2'd3) state_d = WR_CTRL;
      if (state_q == WR_CTRL) state_d = POLL;
      if (state_q == POLL) begin
        busy_d = busy_q | wbm_dat_i[3];
        poll_d = poll_q + 16'd1;
        state_d = (busy_q && wbm_dat_i[3:0] == 4'h0) ? RD_TAG :
                  (poll_d == 16'(POLL_LIMIT))        ? ERR : POLL;
      end
      if (state_q == RD_TAG) begin
        tag_d[{idx_q, 5'b0} +: 32] = wbm_dat_i;
        if (idx_q == 2'd3) state_d = DONE;
      end
    end else if (stb_q) begin
      // Timeout counts cycles with stb high, so stb stays up exactly ACK_TIMEOUT cycles.
      if (to_q == 16'(ACK_TIMEOUT - 1)) begin
        stb_d   = 1'b0;
        we_d    = 1'b0;
        state_d = ERR;
      end else begin
        to_d = to_q + 16'd1;
      end
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      to_q    <= '0;
      poll_q  <= '0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tag_q   <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      mode_q  <= '0;
      ad_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      poll_q  <= poll_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tag_q   <= tag_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      mode_q  <= mode_d;
      ad_q    <= ad_d;
      len_q   <= len_d;
    end
  end
endmodule

// File: tb/tb_ascon_wb_master.sv
// tb_ascon_wb_master: directed bench with a Wishbone slave model and an on-bus protocol monitor.
module tb_ascon_wb_master;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [127:0] KEY   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NONCE = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] NOM_TAG = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [31:0] NOM_ADR [19] = '{
    32'h3000_0008, 32'h3000_000C, 32'h3000_0010, 32'h3000_0014,
    32'h3000_0018, 32'h3000_001C, 32'h3000_0020, 32'h3000_0024,
    32'h3000_0004, 32'h3000_0000, 32'h3000_0000, 32'h3000_0000,
    32'h3000_0000, 32'h3000_0000, 32'h3000_0000,
    32'h3000_0038, 32'h3000_003C, 32'h3000_0040, 32'h3000_0044};
  localparam logic [31:0] NOM_WDAT [8] = '{
    32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203,
    32'h1C1D1E1F, 32'h18191A1B, 32'h14151617, 32'h10111213};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc, stb, we, ack_r, cmd_valid, cmd_ready, done_o, err_o;
  logic [3:0] sel;
  logic [31:0] adr, dat_o, rdat;
  logic [1:0] cmd_mode;
  logic [4:0] cmd_ad_len;
  logic [6:0] cmd_datalen;
  logic [127:0] cmd_key, cmd_nonce, tag_o;
  int nvec = 0, nerr = 0;

  ascon_wb_master dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(rdat), .wbm_ack_i(ack_r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_ad_len(cmd_ad_len), .cmd_datalen(cmd_datalen), .cmd_key(cmd_key),
    .cmd_nonce(cmd_nonce), .tag_o(tag_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave: registered ack one cycle after stb, optional never-ack address, scripted status.
  logic [31:0] nack_adr = 32'hFFFF_FFFF, tag_base = 32'hA0;
  int busy_reads = 5, sts_base = 0, sts_n = 0, log_n = 0;
  logic [31:0] log_adr [4096];
  logic [31:0] log_dat [4096];
  logic log_we [4096];
  initial ack_r = 1'b0;
  initial rdat = 32'h0;
  always @(posedge clk) begin
    ack_r <= cyc && stb && !ack_r && adr != nack_adr;
    if (stb && ack_r) begin
      log_adr[log_n] <= adr;
      log_dat[log_n] <= dat_o;
      log_we[log_n]  <= we;
      log_n <= log_n + 1;
      if (adr == BASE && !we) sts_n <= sts_n + 1;
    end
    rdat <= adr == BASE ? ((sts_n - sts_base < busy_reads) ? 32'h9 : 32'h0) :
            adr >= BASE + 32'h38 ? tag_base + ((adr - BASE - 32'h38) >> 2) : 32'hDEAD_BEEF;
  end

  logic stb_prev = 1'b0, ack_prev = 1'b0, after_ack = 1'b0;
  logic [31:0] adr_prev = '0;
  int gap = 0, n_done = 0, n_rise = 0, run = 0, last_run = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      after_ack = 1'b0;
      stb_prev  = 1'b0;
      ack_prev  = 1'b0;
    end else begin
      if (ack_prev) chk("stb_low_after_ack", stb, 0);
      if (stb && stb_prev && !ack_prev) chk("adr_hold", adr, adr_prev);
      if (stb) chk("sel", sel, 4'hF);
      if (stb && !stb_prev) n_rise++;
      if (stb) run = stb_prev ? run + 1 : 1;
      else if (stb_prev) last_run = run;
      if (stb && !stb_prev && after_ack) begin
        chk("gap_cycles", gap, 1);
        after_ack = 1'b0;
      end else if (after_ack && !stb) gap++;
      if (stb && ack_r) begin
        after_ack = 1'b1;
        gap = 0;
      end
      if (done_o) begin
        n_done++;
        after_ack = 1'b0;
      end
      stb_prev = stb;
      ack_prev = stb && ack_r;
      adr_prev = adr;
    end
  end

  task automatic issue(input logic [1:0] m, input logic [4:0] a, input logic [6:0] l);
    @(negedge clk);
    cmd_key = KEY;
    cmd_nonce = NONCE;
    cmd_mode = m;
    cmd_ad_len = a;
    cmd_datalen = l;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_key = '1;
    cmd_nonce = '0;
    cmd_mode = ~m;
    repeat (8) @(negedge clk);
    chk("cmd_ready_busy", cmd_ready, 0);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    chk("done_o", done_o, 1);
  endtask

  task automatic check_log(input int b, input logic [31:0] ctrl);
    for (int k = 0; k < 19; k++) begin
      chk("log_adr", log_adr[b + k], NOM_ADR[k]);
      chk("log_we", log_we[b + k], k < 9);
      if (k < 8) chk("log_wdat", log_dat[b + k], NOM_WDAT[k]);
      if (k == 8) chk("log_ctrl", log_dat[b + k], ctrl);
    end
  endtask

  int lb, sb, db, rb;
  initial begin
    cmd_valid = 1'b0;
    cmd_mode = '0;
    cmd_ad_len = '0;
    cmd_datalen = '0;
    cmd_key = '0;
    cmd_nonce = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_sel", sel, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);

    // Nominal operation
    lb = log_n; sb = sts_n; sts_base = sts_n; db = n_done;
    issue(2'd1, 5'd3, 7'd16);
    wait_done(500);
    chk("nom_err", err_o, 0);
    chk("nom_tag", tag_o, NOM_TAG);
    repeat (5) @(negedge clk);
    chk("nom_done_pulses", n_done - db, 1);
    chk("nom_xfers", log_n - lb, 19);
    chk("nom_status_reads", sts_n - sb, 6);
    check_log(lb, 32'h0000_A310);

    // Second key write never acknowledged
    nack_adr = BASE + 32'h0C;
    lb = log_n;
    issue(2'd1, 5'd3, 7'd16);
    wait_done(200);
    chk("to_err", err_o, 1);
    chk("to_stb_cycles", last_run, 16);
    chk("to_stb_dropped", stb, 0);
    chk("to_xfers", log_n - lb, 1);
    rb = n_rise;
    repeat (30) @(negedge clk);
    chk("to_no_more_bus", n_rise - rb, 0);
    chk("to_tag_kept", tag_o, NOM_TAG);
    nack_adr = 32'hFFFF_FFFF;

    // Status never reports busy
    busy_reads = 0;
    lb = log_n; sb = sts_n; sts_base = sts_n;
    issue(2'd1, 5'd3, 7'd16);
    wait_done(5000);
    chk("poll_err", err_o, 1);
    chk("poll_reads", sts_n - sb, 1024);
    chk("poll_xfers", log_n - lb, 1033);
    chk("poll_tag_kept", tag_o, NOM_TAG);
    repeat (3) @(negedge clk);

    // Reset in the middle of a nonce write, then a fresh command
    busy_reads = 5;
    tag_base = 32'h1234_5670;
    sts_base = sts_n;
    issue(2'd1, 5'd3, 7'd16);
    for (int i = 0; i < 100; i++) begin
      if (stb && adr == BASE + 32'h18) break;
      @(negedge clk);
    end
    chk("rst_mid_seen_stb", stb, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc", cyc, 0);
    chk("rst_mid_stb", stb, 0);
    chk("rst_mid_tag", tag_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_ready", cmd_ready, 1);
    lb = log_n; sb = sts_n; sts_base = sts_n;
    issue(2'd2, 5'h1F, 7'h7F);
    wait_done(500);
    chk("post_rst_err", err_o, 0);
    chk("post_rst_tag", tag_o, 128'h12345673_12345672_12345671_12345670);
    chk("post_rst_xfers", log_n - lb, 19);
    chk("post_rst_status_reads", sts_n - sb, 6);
    check_log(lb, 32'h0000_DF7F);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
